// File: rtl/polar_pkg.sv
// Shared types and constants for the polar frame packer.
// A frame is HEADER, r, theta, and a checksum byte.
package polar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BR,
        ST_BT,
        ST_CHK
    } state_t;

    localparam int         FRAME_LEN      = 4;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic logic [7:0] frame_checksum(input logic [7:0] header,
                                                  input logic [7:0] r,
                                                  input logic [7:0] theta);
        return header ^ r ^ theta;
    endfunction

endpackage

// File: rtl/polar_fifo.sv
// Synchronous FIFO with a combinational head read; push while full and
// pop while empty are silently ignored.
module polar_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] DEPTH_CNT = DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/polar_frame_packer.sv
// Buffers (r, theta) pairs and serialises each into a 4-byte frame:
// HEADER, r, theta, HEADER^r^theta, with out_last on the checksum byte.
module polar_frame_packer
    import polar_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_r,
    input  logic [7:0]                    in_theta,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    frame_count
);

    state_t      state;
    state_t      next_state;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] head;
    logic [7:0]  hold_r;
    logic [7:0]  hold_theta;

    assign in_ready = !fifo_full;

    polar_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({in_r, in_theta}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        out_valid  = 1'b1;
        out_data   = 8'h00;
        out_last   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                out_valid = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_HDR;
                end
            end
            ST_HDR: begin
                out_data = HEADER;
                if (out_ready) next_state = ST_BR;
            end
            ST_BR: begin
                out_data = hold_r;
                if (out_ready) next_state = ST_BT;
            end
            ST_BT: begin
                out_data = hold_theta;
                if (out_ready) next_state = ST_CHK;
            end
            ST_CHK: begin
                out_data = frame_checksum(HEADER, hold_r, hold_theta);
                out_last = 1'b1;
                // Chain straight into the next frame when one is waiting.
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = ST_HDR;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold_r      <= 8'h00;
            hold_theta  <= 8'h00;
            frame_count <= 8'h00;
        end else begin
            state <= next_state;
            if (pop) begin
                hold_r     <= head[15:8];
                hold_theta <= head[7:0];
            end
            if (state == ST_CHK && out_ready) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_polar_frame_packer.sv
// Randomised and directed bench for polar_frame_packer against a queue-based
// model of buffered pairs and pending frame bytes.
`timescale 1ns/1ps
module tb_polar_frame_packer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_r = 8'h00;
    logic [7:0] in_theta = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] fifo_count;
    logic [7:0] frame_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_fifo[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  exp_frames;
    logic [7:0]  seen[$];
    int          frames_sent;
    logic        last_accept;
    logic        obs_valid;

    polar_frame_packer #(
        .FIFO_DEPTH (DEPTH),
        .HEADER     (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_r        (in_r),
        .in_theta    (in_theta),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .fifo_count  (fifo_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge; reset takes effect at once.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_output("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check_output("rst_out_data", {8'd0, out_data}, 16'd0);
        check_output("rst_out_last", {15'd0, out_last}, 16'd0);
        check_output("rst_fifo_count", {13'd0, fifo_count}, 16'd0);
        check_output("rst_frame_count", {8'd0, frame_count}, 16'd0);
        exp_fifo.delete();
        exp_bytes.delete();
        exp_frames  = 8'd0;
        frames_sent = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("rst_in_ready", {15'd0, in_ready}, 16'd1);
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic apply_stimulus(input logic v, input logic [7:0] r, input logic [7:0] t, input logic ordy);
        logic        fire;
        logic        can_pop;
        logic [15:0] pair;
        in_valid  = v;
        in_r      = r;
        in_theta  = t;
        out_ready = ordy;
        @(negedge clk);
        check_output("out_valid", {15'd0, out_valid}, {15'd0, exp_bytes.size() != 0});
        check_output("out_data", {8'd0, out_data}, (exp_bytes.size() != 0) ? {8'd0, exp_bytes[0]} : 16'd0);
        check_output("out_last", {15'd0, out_last}, {15'd0, exp_bytes.size() == 1});
        check_output("fifo_count", {13'd0, fifo_count}, 16'(exp_fifo.size()));
        check_output("in_ready", {15'd0, in_ready}, {15'd0, exp_fifo.size() < DEPTH});
        check_output("frame_count", {8'd0, frame_count}, {8'd0, exp_frames});
        obs_valid = out_valid;
        if (out_valid && ordy) seen.push_back(out_data);

        fire        = (exp_bytes.size() != 0) && ordy;
        can_pop     = (exp_bytes.size() == 0) || (exp_bytes.size() == 1 && ordy);
        last_accept = v && (exp_fifo.size() < DEPTH);
        if (fire) begin
            if (exp_bytes.size() == 1) begin
                exp_frames = exp_frames + 8'd1;
                frames_sent++;
            end
            void'(exp_bytes.pop_front());
        end
        if (can_pop && exp_fifo.size() != 0) begin
            pair = exp_fifo.pop_front();
            exp_bytes.push_back(8'hA5);
            exp_bytes.push_back(pair[15:8]);
            exp_bytes.push_back(pair[7:0]);
            exp_bytes.push_back(8'hA5 ^ pair[15:8] ^ pair[7:0]);
        end
        if (last_accept) exp_fifo.push_back({r, t});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] frame_a [4];
        logic [7:0] frame_b [4];
        int         cnt;
        int         pushed;
        bit         done;

        frame_a = '{8'hA5, 8'h05, 8'h35, 8'h95};
        frame_b = '{8'hA5, 8'h0A, 8'h00, 8'hAF};

        @(posedge clk);
        #1;
        do_reset();

        // Single frame r=5, theta=53.
        seen.delete();
        apply_stimulus(1'b1, 8'd5, 8'd53, 1'b1);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        check_output("single_len", 16'(seen.size()), 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) check_output("single_byte", {8'd0, seen[i]}, {8'd0, frame_a[i]});
        end
        check_output("single_frames", {8'd0, frame_count}, 16'd1);

        // Backpressure with out_ready 1,0,0,1 repeating.
        do_reset();
        seen.delete();
        apply_stimulus(1'b1, 8'd10, 8'd0, 1'b1);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 8'h00, 8'h00, (i % 4 == 0) || (i % 4 == 3));
        check_output("bp_len", 16'(seen.size()), 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) check_output("bp_byte", {8'd0, seen[i]}, {8'd0, frame_b[i]});
        end

        // Fill with the output stalled: the first pair moves into the holding registers.
        do_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        check_output("fill_in_ready", {15'd0, in_ready}, 16'd0);
        check_output("fill_count", {13'd0, fifo_count}, 16'd4);
        apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        check_output("fill_blocked", {13'd0, fifo_count}, 16'd4);
        for (int i = 0; i < 25; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        check_output("fill_drained", {13'd0, fifo_count}, 16'd0);
        check_output("fill_frames", {8'd0, frame_count}, 16'd5);

        // Back-to-back frames with no idle bubble.
        do_reset();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
            if (obs_valid) cnt++;
            else if (cnt > 0) break;
        end
        check_output("b2b_valid_cycles", 16'(cnt), 16'd12);
        check_output("b2b_frames", {8'd0, frame_count}, 16'd3);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset while the r byte is on the output.
        do_reset();
        apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (exp_bytes.size() == 3) done = 1'b1;
            else apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        end
        if (!done) begin
            total++;
            bad++;
            $error("[TB] FAIL midreset_reach observed=timeout expected=BR");
        end
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);

        // 256 frames: frame_count wraps and FIFO pointers wrap many times.
        do_reset();
        pushed = 0;
        done   = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            apply_stimulus(pushed < 256, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            if (last_accept) pushed++;
            if (frames_sent == 256) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $error("[TB] FAIL wrap_timeout observed=%0d expected=256", frames_sent);
        end
        check_output("wrap_frame_count", {8'd0, frame_count}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
